button_conditioner: RTL and testbench

Conditions the raw push-button inputs (up, down, left, right, middle_click) before they reach the engine top-level control logic. Per button it provides a two-flop synchronizer, a counter-based debouncer, single-cycle press and release pulses, and a hold-to-repeat pulse train. The manual, semi-auto and auto controllers consume the clean levels and pulses instead of the bouncing pad signals.

---
 rtl/button_conditioner.sv | 104 ++++++++++
 tb/tb_button_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-button conditioning for the raw pad inputs: two-flop synchronizer, counter debouncer,
// registered press/release pulses and a hold-to-repeat pulse train. Channels are independent.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] level_dly_q;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic [N_BTN-1:0] toggle_s;
  logic [DW-1:0]    db_cnt_q   [N_BTN];
  logic [DW-1:0]    db_cnt_d   [N_BTN];
  logic [HW-1:0]    hold_cnt_q [N_BTN];
  logic [HW-1:0]    hold_cnt_d [N_BTN];

  // Debounce and hold-counter next state for every channel
  always_comb begin
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    toggle_s   = '0;
    repeat_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        toggle_s[i] = 1'b1;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end

      // A release on the same edge as a due repeat clears the counter and suppresses the pulse
      if (!level_q[i] || toggle_s[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] == HOLD_LAST) begin
        hold_cnt_d[i] = HOLD_RELOAD;
        repeat_d[i]   = 1'b1;
      end else begin
        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
      end
    end
  end

  assign level_d   = level_q ^ toggle_s;
  assign press_d   = level_q & ~level_dly_q;
  assign release_d = ~level_q & level_dly_q;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: constant vector table, directed timing sequences,
// and randomized per-button stimulus compared against a sample-window reference model.
module tb_button_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int RC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: level flips once the last DB synchronized samples all disagree with it
  logic [DB+1:0] m_hist [NB];
  logic [NB-1:0] m_lvl, m_prs, m_rel, m_rpt, m_rose, m_fell;
  int            m_rise [NB];

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = '0;
      m_rise[i] = 0;
    end
    m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0; m_rose = '0; m_fell = '0;
  endtask

  task automatic model_edge(input logic rst_v, input logic [NB-1:0] raw_v);
    logic nl;
    int   d;
    if (!rst_v) begin
      model_reset();
    end else begin
      for (int i = 0; i < NB; i++) begin
        m_hist[i] = {m_hist[i][DB:0], raw_v[i]};
        nl = (m_hist[i][DB+1:2] == {DB{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
        m_prs[i] = m_rose[i];
        m_rel[i] = m_fell[i];
        m_rpt[i] = 1'b0;
        if (m_lvl[i] && nl) begin
          d = cyc - m_rise[i];
          if (d >= HC && ((d - HC) % RC) == 0) m_rpt[i] = 1'b1;
        end
        m_rose[i] = !m_lvl[i] && nl;
        m_fell[i] = m_lvl[i] && !nl;
        if (m_rose[i]) m_rise[i] = cyc;
        m_lvl[i] = nl;
      end
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst_v, input logic [NB-1:0] raw_v);
    @(negedge clk);
    reset   = rst_v;
    btn_raw = raw_v;
    @(posedge clk);
    model_edge(rst_v, raw_v);
    #1;
    chk("model_level",   btn_level,   m_lvl);
    chk("model_press",   btn_press,   m_prs);
    chk("model_release", btn_release, m_rel);
    chk("model_repeat",  btn_repeat,  m_rpt);
  endtask

  typedef struct {
    logic          rst;
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl, prs, rel, rpt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] l,
                              input logic [NB-1:0] p, input logic [NB-1:0] rl, input logic [NB-1:0] rp);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = l; v.prs = p; v.rel = rl; v.rpt = rp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [NB];
    int rst_left;
    logic [NB-1:0] raw;
    model_reset();

    // Reset with all buttons held, then a glitch on button 0
    for (int j = 0; j < 3; j++) tbl.push_back(mk(1'b0, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00));
    for (int e = 0; e < 9; e++)
      tbl.push_back(mk(1'b1, 5'h1F, (e >= 5) ? 5'h1F : 5'h00, (e == 6) ? 5'h1F : 5'h00, 5'h00, 5'h00));
    for (int j = 0; j < 2; j++) tbl.push_back(mk(1'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00));
    for (int j = 0; j < 3; j++) tbl.push_back(mk(1'b1, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00));
    for (int j = 0; j < 8; j++) tbl.push_back(mk(1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].raw);
      chk("tbl_level",   btn_level,   tbl[k].lvl);
      chk("tbl_press",   btn_press,   tbl[k].prs);
      chk("tbl_release", btn_release, tbl[k].rel);
      chk("tbl_repeat",  btn_repeat,  tbl[k].rpt);
    end

    // Clean press and release on button 1
    for (int e = 0; e < 32; e++) begin
      step(1'b1, (e < 20) ? 5'h02 : 5'h00);
      chk("clean_level1",   {4'b0000, btn_level[1]},   {4'b0000, (e >= 5 && e < 25)});
      chk("clean_press1",   {4'b0000, btn_press[1]},   {4'b0000, (e == 6)});
      chk("clean_release1", {4'b0000, btn_release[1]}, {4'b0000, (e == 26)});
    end
    repeat (10) step(1'b1, 5'h00);

    // Auto-repeat on button 2: level rises at edge 5, falls at edge 23
    for (int e = 0; e < 36; e++) begin
      step(1'b1, (e < 18) ? 5'h04 : 5'h00);
      chk("autorep_repeat2", {4'b0000, btn_repeat[2]}, {4'b0000, (e == 15 || e == 18 || e == 21)});
    end
    repeat (10) step(1'b1, 5'h00);

    // Release lands on the edge of the second repeat
    for (int e = 0; e < 30; e++) begin
      step(1'b1, (e < 13) ? 5'h04 : 5'h00);
      chk("collide_level2",   {4'b0000, btn_level[2]},   {4'b0000, (e >= 5 && e < 18)});
      chk("collide_repeat2",  {4'b0000, btn_repeat[2]},  {4'b0000, (e == 15)});
      chk("collide_release2", {4'b0000, btn_release[2]}, {4'b0000, (e == 19)});
    end
    repeat (10) step(1'b1, 5'h00);

    // Simultaneous press on buttons 0 and 4, then reset while held
    for (int e = 0; e < 9; e++) begin
      step(1'b1, 5'h11);
      chk("simul_press", btn_press, (e == 6) ? 5'h11 : 5'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_level",   btn_level,   5'h00);
    chk("midreset_press",   btn_press,   5'h00);
    chk("midreset_release", btn_release, 5'h00);
    chk("midreset_repeat",  btn_repeat,  5'h00);
    step(1'b0, 5'h11);
    for (int e = 0; e < 9; e++) begin
      step(1'b1, 5'h11);
      chk("after_reset_press", btn_press, (e == 6) ? 5'h11 : 5'h00);
      chk("after_reset_level", btn_level, (e >= 5) ? 5'h11 : 5'h00);
    end

    // Randomized run lengths per button with occasional resets
    raw = '0;
    for (int i = 0; i < NB; i++) cnt[i] = $urandom_range(1, 25);
    rst_left = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          raw[i] = ~raw[i];
          cnt[i] = $urandom_range(1, 25);
        end
      end
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        step(1'b0, raw);
        rst_left--;
      end else begin
        step(1'b1, raw);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
